fu_rr_scheduler: RTL

Round-robin scheduler that shares one registered 16-bit functional unit (FU, 1-cycle latency, 5-bit instruction, 16 opcodes) among NUM_REQ requesters. Each requester uses a valid/ready handshake. The scheduler drives the FU operand/instruction inputs, tracks the in-flight operation, and returns each result on a single tagged response channel with backpressure. It sits between the requester clients and the FU instance in the datapath top.

---
 rtl/fu_pkg.sv | 33 +++
 rtl/fu_resp_fifo.sv | 54 +++++
 rtl/fu_rr_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fu_pkg.sv
// Shared definitions for the functional-unit scheduler slice.
// Holds the datapath widths, FU opcode constants and the result-entry
// struct that travels through the response FIFO.
package fu_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int INS_WIDTH    = 5;
    // Widest requester tag supported (NUM_REQ up to 8).
    localparam int ID_MAX_WIDTH = 3;

    localparam logic [INS_WIDTH-1:0] OP_PASS_A = 5'b00000;
    localparam logic [INS_WIDTH-1:0] OP_INC    = 5'b00001;
    localparam logic [INS_WIDTH-1:0] OP_DEC    = 5'b00010;
    localparam logic [INS_WIDTH-1:0] OP_PASS_B = 5'b00011;
    localparam logic [INS_WIDTH-1:0] OP_ADD    = 5'b00100;
    localparam logic [INS_WIDTH-1:0] OP_SUB    = 5'b00101;
    localparam logic [INS_WIDTH-1:0] OP_AND    = 5'b01000;
    localparam logic [INS_WIDTH-1:0] OP_OR     = 5'b01001;
    localparam logic [INS_WIDTH-1:0] OP_XOR    = 5'b01010;
    localparam logic [INS_WIDTH-1:0] OP_NOT    = 5'b01011;
    localparam logic [INS_WIDTH-1:0] OP_SHL    = 5'b01100;
    localparam logic [INS_WIDTH-1:0] OP_SHR    = 5'b01101;
    localparam logic [INS_WIDTH-1:0] OP_ASR    = 5'b01110;
    localparam logic [INS_WIDTH-1:0] OP_MUL    = 5'b10000;
    localparam logic [INS_WIDTH-1:0] OP_ROR    = 5'b10010;
    localparam logic [INS_WIDTH-1:0] OP_ROL    = 5'b10011;

    typedef struct packed {
        logic [ID_MAX_WIDTH-1:0] id;
        logic [DATA_WIDTH-1:0]   data;
    } resp_entry_t;

endpackage

// File: rtl/fu_resp_fifo.sv
// Two-entry synchronous FIFO holding tagged FU results.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push         write push_entry at the tail
//   push_entry   {id, data} to store
//   pop          drop the head entry (caller only pops when count != 0)
//   count        number of stored entries (0..2)
//   head         oldest entry; all-zero after reset
module fu_resp_fifo
    import fu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  resp_entry_t push_entry,
    input  logic        pop,
    output logic [1:0]  count,
    output resp_entry_t head
);

    resp_entry_t mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // The upstream credit check must make these impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && count_q == 2'd2 && !pop))
        else $error("fu_resp_fifo overflow");
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && count_q == 2'd0))
        else $error("fu_resp_fifo underflow");

endmodule

// File: rtl/fu_rr_scheduler.sv
// Round-robin scheduler sharing one registered 1-cycle FU among NUM_REQ
// requesters; results return in issue order on one tagged response channel.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        per-requester handshake (ready one-hot or zero)
//   req_a/req_b/req_ins        packed per-requester operands and instruction
//   fu_a/fu_b/fu_ins           FU inputs (zero when nothing issues)
//   fu_f                       FU result, valid one cycle after issue
//   resp_valid/resp_ready      response handshake
//   resp_id/resp_data          requester tag and result of the response
//   issue_cnt                  wrapping count of issued operations
module fu_rr_scheduler
    import fu_pkg::*;
#(
    parameter int  DATA_WIDTH = fu_pkg::DATA_WIDTH,
    parameter int  INS_WIDTH  = fu_pkg::INS_WIDTH,
    parameter int  NUM_REQ    = 4,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*INS_WIDTH-1:0]  req_ins,
    output logic [DATA_WIDTH-1:0]         fu_a,
    output logic [DATA_WIDTH-1:0]         fu_b,
    output logic [INS_WIDTH-1:0]          fu_ins,
    input  logic [DATA_WIDTH-1:0]         fu_f,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_WIDTH-1:0]           resp_id,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [15:0]                   issue_cnt
);

    logic [ID_WIDTH-1:0]   rr_ptr_q;
    logic                  inflight_q;
    logic [ID_WIDTH-1:0]   inflight_id_q;
    logic [15:0]           issue_cnt_q;

    logic [1:0]            fifo_count;
    resp_entry_t           head;
    resp_entry_t           push_entry;
    logic                  pop;
    logic                  issue_en;
    logic [2:0]            outstanding;

    logic                  found;
    logic                  transfer;
    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   idx;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [INS_WIDTH-1:0]  sel_ins;

    // Credit: a slot freed by this cycle's pop may be reused by this cycle's issue.
    assign resp_valid  = (fifo_count != 2'd0);
    assign pop         = resp_valid & resp_ready;
    assign outstanding = 3'(inflight_q) + 3'(fifo_count);
    assign issue_en    = (outstanding - 3'(pop)) < 3'd2;

    // Scan from rr_ptr upward; iterating from the far end lets the nearest hit win.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx     = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_ins = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                found   = 1'b1;
                winner  = idx;
                sel_a   = req_a[idx*DATA_WIDTH +: DATA_WIDTH];
                sel_b   = req_b[idx*DATA_WIDTH +: DATA_WIDTH];
                sel_ins = req_ins[idx*INS_WIDTH +: INS_WIDTH];
            end
        end
    end

    assign transfer  = found & issue_en;
    assign req_ready = transfer ? (NUM_REQ'(1) << winner) : '0;
    assign fu_a      = transfer ? sel_a : '0;
    assign fu_b      = transfer ? sel_b : '0;
    assign fu_ins    = transfer ? sel_ins : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
            issue_cnt_q   <= 16'd0;
        end else begin
            inflight_q <= transfer;
            if (transfer) begin
                rr_ptr_q      <= (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                inflight_id_q <= winner;
                issue_cnt_q   <= issue_cnt_q + 16'd1;
            end
        end
    end

    assign push_entry = '{id: ID_MAX_WIDTH'(inflight_id_q), data: fu_f};

    fu_resp_fifo u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (fifo_count),
        .head       (head)
    );

    assign resp_id   = head.id[ID_WIDTH-1:0];
    assign resp_data = head.data;
    assign issue_cnt = issue_cnt_q;

    generate
        if (ID_WIDTH < ID_MAX_WIDTH) begin : g_id_pad
            logic unused_id_bits;
            assign unused_id_bits = ^head.id[ID_MAX_WIDTH-1:ID_WIDTH];
        end
    endgenerate

endmodule
